// File: rtl/md_vec_pkg.sv
// Shared definitions for the tagged 97-bit force vector: null flag on top,
// three fp32 lanes (z,y,x) below it.
package md_vec_pkg;

  localparam int VEC_W    = 97;
  localparam int NULL_BIT = 96;
  localparam int FP_W     = 32;

  localparam int X_OFF = 0;
  localparam int Y_OFF = 32;
  localparam int Z_OFF = 64;

  localparam logic [VEC_W-1:0] NULL_VEC = {1'b1, 96'b0};

  function automatic logic is_null(input logic [VEC_W-1:0] v);
    return v[NULL_BIT];
  endfunction

endpackage

// File: rtl/wb_tracker.sv
// Address tracker for in-flight read-modify-writes: a shift register of
// {valid, addr} entries with a hazard match port and a writeback slot tap.
module wb_tracker #(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 8,
  parameter int SLOT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              slot_keep,
  input  logic [ADDR_W-1:0] query_addr,
  output logic              match,
  output logic              any_valid,
  output logic              slot_valid,
  output logic [ADDR_W-1:0] slot_addr
);

  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_addr [DEPTH];

  // Past the slot an entry survives only if its write was issued, so the
  // last stage shadows the pending cache write for hazard purposes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_addr[i] <= '0;
    end else begin
      r_valid[0] <= push;
      r_addr[0]  <= push_addr;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= (i == SLOT + 1) ? (r_valid[i-1] & slot_keep) : r_valid[i-1];
        r_addr[i]  <= r_addr[i-1];
      end
    end
  end

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == query_addr)) match = 1'b1;
    end
  end

  assign any_valid  = |r_valid;
  assign slot_valid = r_valid[SLOT];
  assign slot_addr  = r_addr[SLOT];

endmodule

// File: rtl/force_writeback.sv
// Read-modify-write front end of the per-particle force cache: read cached
// force, hand both operands to the vector adder, write the sum back.
module force_writeback
  import md_vec_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int ADD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [VEC_W-1:0]  req_vec,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [VEC_W-2:0]  rd_data,
  output logic [VEC_W-1:0]  add_a,
  output logic [VEC_W-1:0]  add_b,
  input  logic [VEC_W-1:0]  add_o,
  input  logic              add_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [VEC_W-2:0]  wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              err
);

  logic              w_null;
  logic              w_hazard;
  logic              w_accept;
  logic              w_push;
  logic              w_any_valid;
  logic              w_slot_valid;
  logic [ADDR_W-1:0] w_slot_addr;
  logic              w_wb_ok;
  logic              w_err_now;

  logic              r_s1_valid;
  logic [VEC_W-1:0]  r_s1_vec;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [VEC_W-2:0]  r_wr_data;
  logic              r_err;

  // Handshake: a contribution transfers on a rising edge where req_valid and
  // req_ready are both high. req_ready is combinational: low in reset, low
  // when req_addr hits a tracked address, but always high for null vectors.
  assign w_null    = is_null(req_vec);
  assign req_ready = reset & (w_null | ~w_hazard);
  assign w_accept  = req_valid & req_ready;
  assign w_push    = w_accept & ~w_null;

  assign rd_addr = req_addr;
  assign rd_en   = w_push;

  wb_tracker #(
    .DEPTH  (ADD_LAT + 2),
    .ADDR_W (ADDR_W),
    .SLOT   (ADD_LAT)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (reset),
    .push       (w_push),
    .push_addr  (req_addr),
    .slot_keep  (w_wb_ok),
    .query_addr (req_addr),
    .match      (w_hazard),
    .any_valid  (w_any_valid),
    .slot_valid (w_slot_valid),
    .slot_addr  (w_slot_addr)
  );

  // Any disagreement between adder results and the slot suppresses the write.
  assign w_wb_ok   = add_en & w_slot_valid & ~add_o[NULL_BIT];
  assign w_err_now = (add_en & ~w_slot_valid) | (w_slot_valid & ~add_en) |
                     (add_en & add_o[NULL_BIT]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_vec   <= NULL_VEC;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_s1_valid <= w_push;
      r_s1_vec   <= w_push ? req_vec : NULL_VEC;
      r_wr_en    <= w_wb_ok;
      if (w_wb_ok) begin
        r_wr_addr <= w_slot_addr;
        r_wr_data <= add_o[VEC_W-2:0];
      end
      r_err <= r_err | w_err_now;
    end
  end

  // rd_data is the BRAM output register, valid exactly while S1 is occupied.
  assign add_a = r_s1_valid ? {1'b0, rd_data} : NULL_VEC;
  assign add_b = r_s1_vec;

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign busy    = w_any_valid | r_wr_en;
  assign err     = r_err;

endmodule
